// File: rtl/stream_arbiter_if.sv
// Handshake bundle for stream_arbiter: INPUT_COUNT requester streams in, one stream out.
// master is the arbiter's view; slave is the view of whatever surrounds it.
interface stream_arbiter_if #(
  parameter int WORD_WIDTH   = 64,
  parameter int INPUT_COUNT  = 4,
  parameter int SELECT_WIDTH = 2
);
  logic [INPUT_COUNT-1:0]            s_valid;
  logic [INPUT_COUNT-1:0]            s_ready;
  logic [INPUT_COUNT*WORD_WIDTH-1:0] s_data;
  logic [INPUT_COUNT-1:0]            s_last;
  logic                              m_valid;
  logic                              m_ready;
  logic [WORD_WIDTH-1:0]             m_data;
  logic                              m_last;
  logic [SELECT_WIDTH-1:0]           m_source;

  modport master (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, m_source
  );

  modport slave (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_source
  );
endinterface

// File: rtl/stream_arbiter.sv
// Round-robin packet-locking arbiter feeding a registered 2-entry skid stage.
// Grant is held from arbitration until the s_last beat of that packet is accepted.
module stream_arbiter #(
  parameter int WORD_WIDTH   = 64,
  parameter int INPUT_COUNT  = 4,
  parameter int SELECT_WIDTH = 2
) (
  input  logic             clock,
  input  logic             clear,
  stream_arbiter_if.master bus
);

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
  typedef enum logic [1:0] {SKID_EMPTY, SKID_BUSY, SKID_FULL} skid_state_t;

  arb_state_t              arb_state_reg, arb_state_next;
  logic [SELECT_WIDTH-1:0] grant_reg, grant_next;
  logic [SELECT_WIDTH-1:0] last_grant_reg, last_grant_next;

  skid_state_t             skid_state_reg, skid_state_next;
  logic [WORD_WIDTH-1:0]   out_data_reg, out_data_next;
  logic                    out_last_reg, out_last_next;
  logic [SELECT_WIDTH-1:0] out_source_reg, out_source_next;
  logic [WORD_WIDTH-1:0]   skid_data_reg, skid_data_next;
  logic                    skid_last_reg, skid_last_next;
  logic [SELECT_WIDTH-1:0] skid_source_reg, skid_source_next;

  logic [WORD_WIDTH-1:0]   word_array [INPUT_COUNT];
  logic [INPUT_COUNT-1:0]  ready_vec;
  logic                    room;
  logic                    in_beat;
  logic                    out_beat;
  logic                    in_last;
  logic [WORD_WIDTH-1:0]   in_data;
  logic                    rr_found;
  logic [SELECT_WIDTH-1:0] rr_pick;

  generate
    for (genvar gi = 0; gi < INPUT_COUNT; gi++) begin : g_unpack
      assign word_array[gi] = bus.s_data[gi*WORD_WIDTH +: WORD_WIDTH];
    end
  endgenerate

  // Readiness comes only from registers, so nothing upstream sees m_ready combinationally.
  assign room     = (skid_state_reg != SKID_FULL);
  assign in_data  = word_array[grant_reg];
  assign in_last  = bus.s_last[grant_reg];
  assign in_beat  = (arb_state_reg == ARB_LOCKED) && room && bus.s_valid[grant_reg];
  assign out_beat = (skid_state_reg != SKID_EMPTY) && bus.m_ready;

  always_comb begin
    ready_vec = '0;
    if (arb_state_reg == ARB_LOCKED && room) begin
      ready_vec[grant_reg] = 1'b1;
    end
  end

  // Search starts one past the previous winner and wraps around.
  always_comb begin : rr_search
    logic [SELECT_WIDTH:0] cand;
    rr_found = 1'b0;
    rr_pick  = '0;
    cand     = '0;
    for (int i = 1; i <= INPUT_COUNT; i++) begin
      cand = {1'b0, last_grant_reg} + (SELECT_WIDTH+1)'(i);
      if (cand >= (SELECT_WIDTH+1)'(INPUT_COUNT)) begin
        cand = cand - (SELECT_WIDTH+1)'(INPUT_COUNT);
      end
      if (!rr_found && bus.s_valid[cand[SELECT_WIDTH-1:0]]) begin
        rr_found = 1'b1;
        rr_pick  = cand[SELECT_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    arb_state_next  = arb_state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    case (arb_state_reg)
      ARB_IDLE: begin
        if (rr_found) begin
          grant_next     = rr_pick;
          arb_state_next = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (in_beat && in_last) begin
          last_grant_next = grant_reg;
          arb_state_next  = ARB_IDLE;
        end
      end
      default: arb_state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    skid_state_next  = skid_state_reg;
    out_data_next    = out_data_reg;
    out_last_next    = out_last_reg;
    out_source_next  = out_source_reg;
    skid_data_next   = skid_data_reg;
    skid_last_next   = skid_last_reg;
    skid_source_next = skid_source_reg;
    case (skid_state_reg)
      SKID_EMPTY: begin
        if (in_beat) begin
          out_data_next   = in_data;
          out_last_next   = in_last;
          out_source_next = grant_reg;
          skid_state_next = SKID_BUSY;
        end
      end
      SKID_BUSY: begin
        if (in_beat && !out_beat) begin
          skid_data_next   = in_data;
          skid_last_next   = in_last;
          skid_source_next = grant_reg;
          skid_state_next  = SKID_FULL;
        end else if (in_beat && out_beat) begin
          out_data_next   = in_data;
          out_last_next   = in_last;
          out_source_next = grant_reg;
        end else if (out_beat) begin
          skid_state_next = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (out_beat) begin
          out_data_next   = skid_data_reg;
          out_last_next   = skid_last_reg;
          out_source_next = skid_source_reg;
          skid_state_next = SKID_BUSY;
        end
      end
      default: skid_state_next = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      arb_state_reg   <= ARB_IDLE;
      grant_reg       <= '0;
      last_grant_reg  <= SELECT_WIDTH'(INPUT_COUNT - 1);
      skid_state_reg  <= SKID_EMPTY;
      out_data_reg    <= '0;
      out_last_reg    <= 1'b0;
      out_source_reg  <= '0;
      skid_data_reg   <= '0;
      skid_last_reg   <= 1'b0;
      skid_source_reg <= '0;
    end else begin
      arb_state_reg   <= arb_state_next;
      grant_reg       <= grant_next;
      last_grant_reg  <= last_grant_next;
      skid_state_reg  <= skid_state_next;
      out_data_reg    <= out_data_next;
      out_last_reg    <= out_last_next;
      out_source_reg  <= out_source_next;
      skid_data_reg   <= skid_data_next;
      skid_last_reg   <= skid_last_next;
      skid_source_reg <= skid_source_next;
    end
  end

  assign bus.s_ready  = ready_vec;
  assign bus.m_valid  = (skid_state_reg != SKID_EMPTY);
  assign bus.m_data   = out_data_reg;
  assign bus.m_last   = out_last_reg;
  assign bus.m_source = out_source_reg;

endmodule

// File: tb/tb_stream_arbiter.sv
// Bench for stream_arbiter: a cycle table, directed multi-cycle sequences, and a
// randomized run checked against a queue-based model of accepted-versus-emitted beats.
module tb_stream_arbiter;
  localparam int WW = 64;
  localparam int N  = 4;
  localparam int SW = 2;

  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  stream_arbiter_if #(.WORD_WIDTH(WW), .INPUT_COUNT(N), .SELECT_WIDTH(SW)) bus ();

  stream_arbiter #(.WORD_WIDTH(WW), .INPUT_COUNT(N), .SELECT_WIDTH(SW)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  typedef struct packed {
    logic [WW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [WW-1:0] data;
    logic          last;
    logic [SW-1:0] src;
  } word_t;

  typedef struct {
    logic [N-1:0]  valid;
    logic [N-1:0]  last;
    logic [WW-1:0] data;
    logic          mready;
    logic [N-1:0]  exp_sready;
    logic          exp_mvalid;
    logic [WW-1:0] exp_mdata;
    logic          exp_mlast;
    logic [SW-1:0] exp_msrc;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int inflight = 0;
  bit verbose = 1'b1;

  beat_t src_q [N][$];
  word_t exp_q [$];
  word_t out_q [$];
  int    out_cyc [$];
  logic [N-1:0]  hold_off = '0;
  logic          mready_val = 1'b0;
  logic          in_open = 1'b0;
  int            in_src = 0;
  logic          prev_stall = 1'b0;
  word_t         prev_word;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for output (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    out_q.delete();
    out_cyc.delete();
    inflight   = 0;
    hold_off   = '0;
    in_open    = 1'b0;
    prev_stall = 1'b0;
  endtask

  task automatic do_reset();
    clear        = 1'b1;
    bus.s_valid  = '0;
    bus.s_last   = '0;
    bus.s_data   = '0;
    bus.m_ready  = 1'b0;
    mready_val   = 1'b0;
    tick();
    tick();
    clear = 1'b0;
    clear_model();
  endtask

  task automatic push_beat(input int r, input logic [WW-1:0] d, input logic l);
    src_q[r].push_back({d, l});
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !hold_off[i]) begin
        bus.s_valid[i]          = 1'b1;
        bus.s_data[i*WW +: WW]  = src_q[i][0].data;
        bus.s_last[i]           = src_q[i][0].last;
      end else begin
        bus.s_valid[i]          = 1'b0;
        bus.s_data[i*WW +: WW]  = '0;
        bus.s_last[i]           = 1'b0;
      end
    end
    bus.m_ready = mready_val;
  endtask

  // One clock of the requester/consumer model; outputs depend only on DUT registers.
  task automatic cycle();
    word_t w;
    drive();
    check("s_ready_onehot", 128'($onehot0(bus.s_ready)), 128'(1));
    check("m_valid_vs_inflight", 128'(bus.m_valid), 128'(inflight > 0));
    if (|bus.s_ready) check("ready_implies_room", 128'(inflight < 2), 128'(1));
    if (prev_stall) begin
      w = {bus.m_data, bus.m_last, bus.m_source};
      check("stall_stable", 128'(w), 128'(prev_word));
    end
    if (bus.m_valid && bus.m_ready) begin
      w = {bus.m_data, bus.m_last, bus.m_source};
      if (exp_q.size() == 0) begin
        timeout("out_without_input");
      end else begin
        check("out_word", 128'(w), 128'(exp_q.pop_front()));
      end
      out_q.push_back(w);
      out_cyc.push_back(cyc);
      inflight--;
      if (verbose) $display("beat src=%0d data=0x%0h last=%0b cycle=%0d",
                            bus.m_source, bus.m_data, bus.m_last, cyc);
    end
    for (int i = 0; i < N; i++) begin
      if (bus.s_valid[i] && bus.s_ready[i]) begin
        if (in_open) check("packet_lock", 128'(i), 128'(in_src));
        in_open = !bus.s_last[i];
        in_src  = i;
        exp_q.push_back({bus.s_data[i*WW +: WW], bus.s_last[i], SW'(i)});
        void'(src_q[i].pop_front());
        inflight++;
      end
    end
    prev_stall = bus.m_valid && !bus.m_ready;
    prev_word  = {bus.m_data, bus.m_last, bus.m_source};
    tick();
  endtask

  task automatic run_until(input int n_out, input int bound, input string name);
    int k;
    k = 0;
    while (out_q.size() < n_out && k < bound) begin
      cycle();
      k++;
    end
    if (out_q.size() < n_out) timeout(name);
  endtask

  vec_t vecs [8];

  initial begin
    int k;
    int total_gen;
    logic [WW-1:0] t3_data [5];
    logic [SW-1:0] t3_src  [5];
    logic [WW-1:0] t5_data [4];
    logic [SW-1:0] t5_src  [4];

    // Single requester (index 2): three-beat packet, then a one-beat packet right behind it.
    vecs[0] = '{4'b0100, 4'b0000, 64'h11, 1'b1, 4'b0000, 1'b0, 64'h0,  1'b0, 2'd0};
    vecs[1] = '{4'b0100, 4'b0000, 64'h11, 1'b1, 4'b0100, 1'b0, 64'h0,  1'b0, 2'd0};
    vecs[2] = '{4'b0100, 4'b0000, 64'h22, 1'b1, 4'b0100, 1'b1, 64'h11, 1'b0, 2'd2};
    vecs[3] = '{4'b0100, 4'b0100, 64'h33, 1'b1, 4'b0100, 1'b1, 64'h22, 1'b0, 2'd2};
    vecs[4] = '{4'b0100, 4'b0100, 64'h44, 1'b1, 4'b0000, 1'b1, 64'h33, 1'b1, 2'd2};
    vecs[5] = '{4'b0100, 4'b0100, 64'h44, 1'b1, 4'b0100, 1'b0, 64'h0,  1'b0, 2'd0};
    vecs[6] = '{4'b0000, 4'b0000, 64'h0,  1'b1, 4'b0000, 1'b1, 64'h44, 1'b1, 2'd2};
    vecs[7] = '{4'b0000, 4'b0000, 64'h0,  1'b1, 4'b0000, 1'b0, 64'h0,  1'b0, 2'd0};

    // Reset state, then reset in the middle of a packet.
    do_reset();
    check("rst_s_ready", 128'(bus.s_ready), 128'(0));
    check("rst_m_valid", 128'(bus.m_valid), 128'(0));
    check("rst_m_data", 128'(bus.m_data), 128'(0));
    check("rst_m_last", 128'(bus.m_last), 128'(0));
    check("rst_m_source", 128'(bus.m_source), 128'(0));
    push_beat(0, 64'hA1, 1'b0);
    push_beat(0, 64'hA2, 1'b1);
    mready_val = 1'b0;
    cycle();
    cycle();
    check("t1_beat_a_held", 128'(bus.m_valid), 128'(1));
    check("t1_beat_a_data", 128'(bus.m_data), 128'(64'hA1));
    clear = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    for (int i = 0; i < N; i++) push_beat(i, 64'h10 + WW'(i), 1'b1);
    drive();
    tick();
    clear = 1'b0;
    exp_q.delete();
    inflight   = 0;
    in_open    = 1'b0;
    prev_stall = 1'b0;
    check("t1_clr_m_valid", 128'(bus.m_valid), 128'(0));
    check("t1_clr_s_ready", 128'(bus.s_ready), 128'(0));
    check("t1_clr_m_data", 128'(bus.m_data), 128'(0));
    mready_val = 1'b1;
    cycle();
    check("t1_grant0_ready", 128'(bus.s_ready), 128'(4'b0001));
    run_until(1, 10, "t1_first_out");
    if (out_q.size() >= 1) begin
      check("t1_first_src", 128'(out_q[0].src), 128'(0));
      check("t1_first_data", 128'(out_q[0].data), 128'(64'h10));
    end

    // Cycle table.
    do_reset();
    foreach (vecs[r]) begin
      bus.s_valid = vecs[r].valid;
      bus.s_last  = vecs[r].last;
      bus.s_data  = '0;
      bus.s_data[2*WW +: WW] = vecs[r].data;
      bus.m_ready = vecs[r].mready;
      $display("row %0d: s_ready=%b m_valid=%b m_data=0x%0h m_last=%b m_source=%0d",
               r, bus.s_ready, bus.m_valid, bus.m_data, bus.m_last, bus.m_source);
      check($sformatf("tbl%0d_s_ready", r), 128'(bus.s_ready), 128'(vecs[r].exp_sready));
      check($sformatf("tbl%0d_m_valid", r), 128'(bus.m_valid), 128'(vecs[r].exp_mvalid));
      if (vecs[r].exp_mvalid) begin
        check($sformatf("tbl%0d_m_data", r), 128'(bus.m_data), 128'(vecs[r].exp_mdata));
        check($sformatf("tbl%0d_m_last", r), 128'(bus.m_last), 128'(vecs[r].exp_mlast));
        check($sformatf("tbl%0d_m_source", r), 128'(bus.m_source), 128'(vecs[r].exp_msrc));
      end
      tick();
    end

    // All four requesting one-beat packets: strict rotation with one bubble between beats.
    do_reset();
    for (int i = 0; i < N; i++) begin
      push_beat(i, 64'h30 + WW'(i), 1'b1);
      push_beat(i, 64'h40 + WW'(i), 1'b1);
    end
    mready_val = 1'b1;
    run_until(5, 60, "t3_rotation");
    t3_src  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    t3_data = '{64'h30, 64'h31, 64'h32, 64'h33, 64'h40};
    for (int j = 0; j < 5 && j < out_q.size(); j++) begin
      check($sformatf("t3_src%0d", j), 128'(out_q[j].src), 128'(t3_src[j]));
      check($sformatf("t3_data%0d", j), 128'(out_q[j].data), 128'(t3_data[j]));
      if (j > 0) check($sformatf("t3_gap%0d", j), 128'(out_cyc[j] - out_cyc[j-1]), 128'(2));
    end

    // Backpressure mid-packet: two words buffered, then input readiness drops.
    do_reset();
    for (int j = 1; j <= 6; j++) push_beat(1, WW'(j), j == 6);
    k = 0;
    while (out_q.size() < 6 && k < 60) begin
      mready_val = !(k >= 3 && k < 7);
      if (k == 3) check("t4_ready_before_full", 128'(bus.s_ready), 128'(4'b0010));
      if (k == 4) check("t4_ready_dropped", 128'(bus.s_ready), 128'(0));
      if (k == 5) check("t4_two_buffered", 128'(inflight), 128'(2));
      cycle();
      k++;
    end
    if (out_q.size() < 6) timeout("t4_drain");
    for (int j = 0; j < 6 && j < out_q.size(); j++) begin
      check($sformatf("t4_data%0d", j), 128'(out_q[j].data), 128'(j + 1));
      check($sformatf("t4_last%0d", j), 128'(out_q[j].last), 128'(j == 5));
    end

    // Lock hold: requester 0 goes quiet mid-packet while requester 3 waits.
    do_reset();
    push_beat(0, 64'h51, 1'b0);
    push_beat(0, 64'h52, 1'b0);
    push_beat(0, 64'h53, 1'b1);
    push_beat(3, 64'h5F, 1'b1);
    mready_val = 1'b1;
    k = 0;
    while (out_q.size() < 4 && k < 40) begin
      hold_off[0] = (k >= 2 && k < 5);
      if (k >= 2 && k < 5) check($sformatf("t5_hold_ready%0d", k), 128'(bus.s_ready), 128'(4'b0001));
      cycle();
      k++;
    end
    if (out_q.size() < 4) timeout("t5_drain");
    t5_data = '{64'h51, 64'h52, 64'h53, 64'h5F};
    t5_src  = '{2'd0, 2'd0, 2'd0, 2'd3};
    for (int j = 0; j < 4 && j < out_q.size(); j++) begin
      check($sformatf("t5_data%0d", j), 128'(out_q[j].data), 128'(t5_data[j]));
      check($sformatf("t5_src%0d", j), 128'(out_q[j].src), 128'(t5_src[j]));
    end

    // Requester 0 appears in the same cycle requester 3's last beat is taken: wrap to 0.
    do_reset();
    push_beat(3, 64'h61, 1'b0);
    push_beat(3, 64'h62, 1'b1);
    mready_val = 1'b1;
    k = 0;
    while (out_q.size() < 3 && k < 30) begin
      if (k == 2) push_beat(0, 64'h60, 1'b1);
      if (k == 3) check("t6_bubble_ready", 128'(bus.s_ready), 128'(0));
      if (k == 4) check("t6_wrap_ready", 128'(bus.s_ready), 128'(4'b0001));
      cycle();
      k++;
    end
    if (out_q.size() < 3) timeout("t6_drain");
    if (out_q.size() >= 3) begin
      check("t6_src2", 128'(out_q[2].src), 128'(0));
      check("t6_data2", 128'(out_q[2].data), 128'(64'h60));
      check("t6_gap", 128'(out_cyc[2] - out_cyc[1]), 128'(2));
    end

    // Randomized traffic with random stalls on both sides, then a full drain.
    do_reset();
    verbose   = 1'b0;
    total_gen = 0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int r;
        int len;
        r = $urandom_range(0, N - 1);
        if (src_q[r].size() < 8) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) push_beat(r, {$urandom, $urandom}, b == len - 1);
          total_gen += len;
        end
      end
      for (int i = 0; i < N; i++) hold_off[i] = ($urandom_range(0, 3) == 0);
      mready_val = ($urandom_range(0, 3) != 0);
      cycle();
    end
    hold_off   = '0;
    mready_val = 1'b1;
    k = 0;
    while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() > 0
            || inflight > 0) && k < 500) begin
      cycle();
      k++;
    end
    if (k >= 500) timeout("rand_drain");
    check("rand_beat_count", 128'(out_q.size()), 128'(total_gen));
    check("rand_exp_empty", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
